// File: rtl/parking_pkg.sv
// rtl/parking_pkg.sv - shared types and constants for the parking timer blocks
package parking_pkg;

  localparam int CLK_HZ             = 50_000_000;
  localparam int DEFAULT_LOSS_LIMIT = 75_000_000;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  // Returns {carry, digit}; the digit rolls to 0 and carries once it passes max.
  function automatic logic [4:0] bcd_inc(input bcd_digit_t d, input bcd_digit_t max);
    logic [4:0] r;
    if (d >= max) r = {1'b1, 4'h0};
    else          r = {1'b0, d + 4'd1};
    return r;
  endfunction

endpackage

// File: rtl/sync_edge.sv
// rtl/sync_edge.sv - multi-flop synchronizer with rising-edge detect and registered pulse
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise,
  output logic pulse
);

  logic [STAGES-1:0] sync_q;
  logic              prev;

  assign rise = sync_q[STAGES-1] & ~prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      prev   <= 1'b0;
      pulse  <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
      prev   <= sync_q[STAGES-1];
      pulse  <= rise;
    end
  end

endmodule

// File: rtl/sec_tick_timer.sv
// rtl/sec_tick_timer.sv - 1 Hz tick recovery, BCD mm:ss elapsed counter with expiry and loss watchdog
module sec_tick_timer
  import parking_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter int         LOSS_LIMIT  = DEFAULT_LOSS_LIMIT,
  parameter int         LOSS_W      = 27,
  parameter logic [7:0] LIMIT_MIN   = 8'h05
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clk1hz_in,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  output logic       sec_tick,
  output logic       running,
  output logic [7:0] sec_bcd,
  output logic [7:0] min_bcd,
  output logic       expired,
  output logic       tick_lost
);

  localparam logic [LOSS_W-1:0] LOSS_MAX = LOSS_W'(LOSS_LIMIT);

  logic        rise;
  state_t      state;
  state_t      state_next;
  logic        count_en;
  logic        at_max;
  logic [4:0]  sec_lo_inc;
  logic [4:0]  sec_hi_inc;
  logic [4:0]  min_lo_inc;
  logic [4:0]  min_hi_inc;
  logic [7:0]  sec_next;
  logic [7:0]  min_next;
  logic [LOSS_W-1:0] wd_cnt;
  logic [LOSS_W-1:0] wd_next;

  sync_edge #(
    .STAGES(SYNC_STAGES)
  ) u_sync_edge (
    .clk   (clk),
    .reset (reset),
    .d     (clk1hz_in),
    .rise  (rise),
    .pulse (sec_tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      running <= 1'b0;
    end else begin
      state   <= state_next;
      running <= (state_next == ST_RUN);
    end
  end

  // clear beats stop beats start.
  always_comb begin
    state_next = state;
    if (clear) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (start) state_next = ST_RUN;
        ST_RUN:  if (stop)  state_next = ST_HOLD;
        ST_HOLD: if (start) state_next = ST_RUN;
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // Only the current state gates counting, so the edge that arrives with the entry into RUN is dropped.
  always_comb begin
    count_en = 1'b0;
    if (state == ST_RUN && rise && !clear) count_en = 1'b1;
  end

  assign at_max     = (sec_bcd == 8'h59) && (min_bcd == 8'h99);
  assign sec_lo_inc = bcd_inc(sec_bcd[3:0], 4'd9);
  assign sec_hi_inc = bcd_inc(sec_bcd[7:4], 4'd5);
  assign min_lo_inc = bcd_inc(min_bcd[3:0], 4'd9);
  assign min_hi_inc = bcd_inc(min_bcd[7:4], 4'd9);

  always_comb begin
    sec_next = sec_bcd;
    min_next = min_bcd;
    if (!at_max) begin
      sec_next[3:0] = sec_lo_inc[3:0];
      if (sec_lo_inc[4]) begin
        sec_next[7:4] = sec_hi_inc[3:0];
        if (sec_hi_inc[4]) begin
          min_next[3:0] = min_lo_inc[3:0];
          if (min_lo_inc[4]) min_next[7:4] = min_hi_inc[3:0];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sec_bcd <= 8'h00;
      min_bcd <= 8'h00;
      expired <= 1'b0;
    end else if (clear) begin
      sec_bcd <= 8'h00;
      min_bcd <= 8'h00;
      expired <= 1'b0;
    end else if (count_en) begin
      sec_bcd <= sec_next;
      min_bcd <= min_next;
      if (LIMIT_MIN != 8'h00 && min_next == LIMIT_MIN && sec_next == 8'h00)
        expired <= 1'b1;
    end
  end

  always_comb begin
    if (rise)                  wd_next = '0;
    else if (wd_cnt == LOSS_MAX) wd_next = wd_cnt;
    else                       wd_next = wd_cnt + LOSS_W'(1);
  end

  // tick_lost is held until the pulse for the recovering edge has been seen, so it drops one cycle after sec_tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_cnt    <= '0;
      tick_lost <= 1'b0;
    end else begin
      wd_cnt    <= wd_next;
      tick_lost <= (wd_next == LOSS_MAX) || (tick_lost && !sec_tick);
    end
  end

endmodule

// File: tb/tb_sec_tick_timer.sv
// tb/tb_sec_tick_timer.sv - directed self-checking bench for sec_tick_timer
module tb_sec_tick_timer;

  logic       clk = 1'b0;
  logic       reset;
  logic       clk1hz_in;
  logic       start;
  logic       stop;
  logic       clear;
  logic       sec_tick;
  logic       running;
  logic [7:0] sec_bcd;
  logic [7:0] min_bcd;
  logic       expired;
  logic       tick_lost;

  int n_chk  = 0;
  int n_pass = 0;
  int ticks  = 0;
  int t0;

  sec_tick_timer #(
    .SYNC_STAGES (2),
    .LOSS_LIMIT  (50),
    .LOSS_W      (8),
    .LIMIT_MIN   (8'h01)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .clk1hz_in (clk1hz_in),
    .start     (start),
    .stop      (stop),
    .clear     (clear),
    .sec_tick  (sec_tick),
    .running   (running),
    .sec_bcd   (sec_bcd),
    .min_bcd   (min_bcd),
    .expired   (expired),
    .tick_lost (tick_lost)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (sec_tick) ticks++;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic gen_edge();
    clk1hz_in = 1'b1;
    cyc(2);
    clk1hz_in = 1'b0;
    cyc(2);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    cyc();
    stop = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    cyc();
    clear = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    clk1hz_in = 1'b0;
    start     = 1'b0;
    stop      = 1'b0;
    clear     = 1'b0;
    cyc(3);
    chk("rst_sec_tick",  8'(sec_tick),  8'h00);
    chk("rst_running",   8'(running),   8'h00);
    chk("rst_sec",       sec_bcd,       8'h00);
    chk("rst_min",       min_bcd,       8'h00);
    chk("rst_expired",   8'(expired),   8'h00);
    chk("rst_tick_lost", 8'(tick_lost), 8'h00);
    reset = 1'b0;
    cyc(2);

    // latency: rise sampled at k, pulse after k+2
    clk1hz_in = 1'b1;
    cyc(2);
    chk("lat_early", 8'(sec_tick), 8'h00);
    cyc();
    chk("lat_tick", 8'(sec_tick), 8'h01);
    cyc();
    chk("tick_width", 8'(sec_tick), 8'h00);
    cyc(6);
    clk1hz_in = 1'b0;
    t0 = ticks;
    cyc(10);
    chk("fall_no_tick", 8'(ticks - t0), 8'h00);
    clk1hz_in = 1'b1;
    cyc(10);
    clk1hz_in = 1'b0;
    cyc(10);
    chk("one_tick_per_period", 8'(ticks - t0), 8'h01);

    // counting and expiry at 01:00
    pulse_start();
    chk("run_after_start", 8'(running), 8'h01);
    repeat (59) gen_edge();
    chk("cnt59_sec", sec_bcd, 8'h59);
    chk("cnt59_min", min_bcd, 8'h00);
    chk("cnt59_exp", 8'(expired), 8'h00);
    gen_edge();
    chk("cnt60_sec", sec_bcd, 8'h00);
    chk("cnt60_min", min_bcd, 8'h01);
    chk("cnt60_exp", 8'(expired), 8'h01);
    repeat (5) gen_edge();
    chk("cnt65_sec", sec_bcd, 8'h05);
    chk("cnt65_min", min_bcd, 8'h01);
    chk("cnt65_exp", 8'(expired), 8'h01);

    // pause, resume, simultaneous commands
    pulse_clear();
    chk("clr_running", 8'(running), 8'h00);
    chk("clr_sec", sec_bcd, 8'h00);
    chk("clr_min", min_bcd, 8'h00);
    chk("clr_exp", 8'(expired), 8'h00);
    pulse_start();
    repeat (10) gen_edge();
    chk("run10_sec", sec_bcd, 8'h10);
    pulse_stop();
    chk("hold_running", 8'(running), 8'h00);
    repeat (5) gen_edge();
    chk("hold_sec", sec_bcd, 8'h10);
    pulse_start();
    chk("resume_running", 8'(running), 8'h01);
    gen_edge();
    chk("resume_sec", sec_bcd, 8'h11);
    start = 1'b1;
    stop  = 1'b1;
    cyc();
    start = 1'b0;
    stop  = 1'b0;
    chk("startstop_hold", 8'(running), 8'h00);
    gen_edge();
    chk("startstop_sec", sec_bcd, 8'h11);
    pulse_start();
    clk1hz_in = 1'b1;
    cyc(2);
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    chk("clr_edge_tick", 8'(sec_tick), 8'h01);
    chk("clr_edge_sec", sec_bcd, 8'h00);
    chk("clr_edge_running", 8'(running), 8'h00);
    clk1hz_in = 1'b0;
    cyc(2);
    clk1hz_in = 1'b1;
    cyc(2);
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("start_edge_running", 8'(running), 8'h01);
    chk("start_edge_sec", sec_bcd, 8'h00);
    clk1hz_in = 1'b0;
    cyc(2);
    gen_edge();
    chk("after_start_edge_sec", sec_bcd, 8'h01);

    // saturation at 99:59
    pulse_clear();
    pulse_start();
    repeat (5999) gen_edge();
    chk("sat_sec", sec_bcd, 8'h59);
    chk("sat_min", min_bcd, 8'h99);
    chk("sat_exp", 8'(expired), 8'h01);
    repeat (3) gen_edge();
    chk("sat_hold_sec", sec_bcd, 8'h59);
    chk("sat_hold_min", min_bcd, 8'h99);

    // asynchronous reset mid-operation
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("arst_running", 8'(running), 8'h00);
    chk("arst_sec", sec_bcd, 8'h00);
    chk("arst_min", min_bcd, 8'h00);
    chk("arst_exp", 8'(expired), 8'h00);
    cyc(2);
    reset = 1'b0;

    // watchdog from reset release with the source held low
    cyc(49);
    chk("wd_before_limit", 8'(tick_lost), 8'h00);
    chk("post_rst_idle", 8'(running), 8'h00);
    cyc();
    chk("wd_at_limit", 8'(tick_lost), 8'h01);
    clk1hz_in = 1'b1;
    cyc(2);
    chk("wd_still_lost", 8'(tick_lost), 8'h01);
    cyc();
    chk("wd_tick", 8'(sec_tick), 8'h01);
    chk("wd_lost_with_tick", 8'(tick_lost), 8'h01);
    cyc();
    chk("wd_recovered", 8'(tick_lost), 8'h00);
    chk("idle_edge_ignored", sec_bcd, 8'h00);
    clk1hz_in = 1'b0;
    cyc(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
